// File: rtl/seq_startup_ctrl.sv
// Startup/recalibration gate between the memory controller/PLL reconfig and the PHY sequencer.
// Holds off the sequencer until init is done and the phase shifter has been idle for a settle time.
module seq_startup_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int BUSY_TIMEOUT  = 1024,
  parameter int RECAL_HOLD    = 8,
  parameter int CNT_WIDTH     = 16,
  parameter bit BYPASS        = 1'b0
) (
  input  logic       seq_clk,
  input  logic       reset_seq_n,
  input  logic       ctl_init_done,
  input  logic       phs_shft_busy,
  input  logic       recal_req,
  input  logic       seq_cal_done,
  input  logic       seq_cal_success,
  output logic       ctl_init_done_for_seq,
  output logic       phs_shft_busy_for_seq,
  output logic       seq_running,
  output logic [2:0] startup_state,
  output logic       busy_timeout_err,
  output logic       cal_pass_sticky,
  output logic [7:0] cal_count
);

  // state         | meaning
  // IDLE          | waiting for controller init done
  // WAIT_BUSY_LOW | init done, phase shifter busy; timeout counter running
  // SETTLE        | phase shifter idle, counting settle cycles
  // GO            | sequencer enabled, waiting for calibration done
  // CAL_DONE      | calibration complete, sequencer still enabled
  // RECAL         | sequencer held off before restarting the startup sequence
  // ERROR         | phase shifter never went idle; left only by a recal request
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_GO       = 3'd3,
    ST_CAL_DONE = 3'd4,
    ST_RECAL    = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  localparam logic [CNT_WIDTH-1:0] L_ONE         = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] L_SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] L_TO_LAST     = CNT_WIDTH'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] L_HOLD_LAST   = CNT_WIDTH'(RECAL_HOLD - 1);

  logic [SYNC_STAGES-1:0] r_busy_sync;
  logic                   r_recal_d1;
  logic                   r_cal_done_d1;
  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_seq_running;
  logic                   r_err;
  logic                   r_recal_pending;
  logic [7:0]             r_cal_count;
  logic                   r_cal_pass;

  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic                   w_err_nxt;
  logic                   w_pending_nxt;
  logic                   w_cal_take;
  logic                   w_busy_s;
  logic                   w_recal_rise;
  logic                   w_cal_rise;

  assign w_busy_s     = r_busy_sync[SYNC_STAGES-1];
  assign w_recal_rise = recal_req & ~r_recal_d1;
  assign w_cal_rise   = seq_cal_done & ~r_cal_done_d1;

  // Synchroniser resets to busy so nothing proceeds until the PLL is seen idle.
  always_ff @(posedge seq_clk or negedge reset_seq_n) begin
    if (!reset_seq_n) begin
      r_busy_sync   <= '1;
      r_recal_d1    <= 1'b0;
      r_cal_done_d1 <= 1'b0;
    end else begin
      r_busy_sync[0] <= phs_shft_busy;
      for (int i = 1; i < SYNC_STAGES; i++) r_busy_sync[i] <= r_busy_sync[i-1];
      r_recal_d1    <= recal_req;
      r_cal_done_d1 <= seq_cal_done;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_err_nxt     = r_err;
    w_pending_nxt = r_recal_pending;
    w_cal_take    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ctl_init_done) begin
          w_state_nxt = w_busy_s ? ST_WAIT : ST_SETTLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (!ctl_init_done) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == L_TO_LAST) begin
          w_state_nxt = ST_ERROR;
          w_err_nxt   = 1'b1;
        end else if (!w_busy_s) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + L_ONE;
        end
      end
      ST_SETTLE: begin
        if (!ctl_init_done) begin
          w_state_nxt = ST_IDLE;
        end else if (w_busy_s) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == L_SETTLE_LAST) begin
          w_state_nxt = ST_GO;
        end else begin
          w_cnt_nxt = r_cnt + L_ONE;
        end
      end
      ST_GO: begin
        if (!ctl_init_done) begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = 1'b0;
        end else begin
          if (w_recal_rise) w_pending_nxt = 1'b1;
          if (w_cal_rise) begin
            w_state_nxt = ST_CAL_DONE;
            w_cal_take  = 1'b1;
          end
        end
      end
      ST_CAL_DONE: begin
        if (!ctl_init_done) begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = 1'b0;
        end else if (w_recal_rise || r_recal_pending) begin
          w_state_nxt   = ST_RECAL;
          w_cnt_nxt     = '0;
          w_pending_nxt = 1'b0;
        end
      end
      ST_RECAL: begin
        if (r_cnt == L_HOLD_LAST) w_state_nxt = ST_IDLE;
        else                      w_cnt_nxt   = r_cnt + L_ONE;
      end
      ST_ERROR: begin
        if (w_recal_rise) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // In pass-through mode calibration status tracks every cal-done edge.
    if (BYPASS) w_cal_take = w_cal_rise;
  end

  always_ff @(posedge seq_clk or negedge reset_seq_n) begin
    if (!reset_seq_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_seq_running   <= 1'b0;
      r_err           <= 1'b0;
      r_recal_pending <= 1'b0;
      r_cal_count     <= 8'd0;
      r_cal_pass      <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_seq_running   <= (w_state_nxt == ST_GO) || (w_state_nxt == ST_CAL_DONE);
      r_err           <= w_err_nxt;
      r_recal_pending <= w_pending_nxt;
      if (w_cal_take) begin
        if (r_cal_count != 8'hFF) r_cal_count <= r_cal_count + 8'd1;
        r_cal_pass <= seq_cal_success;
      end
    end
  end

  assign ctl_init_done_for_seq = BYPASS ? ctl_init_done : (r_seq_running & ctl_init_done);
  assign phs_shft_busy_for_seq = BYPASS ? phs_shft_busy : (r_seq_running & phs_shft_busy);
  assign seq_running           = BYPASS ? 1'b1 : r_seq_running;
  assign startup_state         = BYPASS ? 3'd3 : r_state;
  assign busy_timeout_err      = BYPASS ? 1'b0 : r_err;
  assign cal_pass_sticky       = r_cal_pass;
  assign cal_count             = r_cal_count;

endmodule

// File: tb/tb_seq_startup_ctrl.sv
// Self-checking bench for seq_startup_ctrl: gated and bypass instances, randomized timing,
// expectations from startup latency arithmetic and a calibration counter model.
module tb_seq_startup_ctrl;

  localparam int SYNC   = 2;
  localparam int SETTLE = 16;
  localparam int TO     = 1024;
  localparam int HOLD   = 8;
  // edges from busy falling (or reset release with busy low) to GO
  localparam int GO_LAT = SYNC + 1 + SETTLE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, init, busy, recal, cal_done, succ;
  logic ctl_o, phs_o, run_o, err_o, pass_o;
  logic [2:0] st_o;
  logic [7:0] cnt_o;

  logic bp_init, bp_busy, bp_recal, bp_cal, bp_succ;
  logic bp_ctl, bp_phs, bp_run, bp_err, bp_pass;
  logic [2:0] bp_st;
  logic [7:0] bp_cnt;

  int n_pass = 0;
  int n_total = 0;

  seq_startup_ctrl #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .BUSY_TIMEOUT(TO),
                     .RECAL_HOLD(HOLD), .CNT_WIDTH(16), .BYPASS(1'b0)) dut (
    .seq_clk(clk), .reset_seq_n(rst_n), .ctl_init_done(init), .phs_shft_busy(busy),
    .recal_req(recal), .seq_cal_done(cal_done), .seq_cal_success(succ),
    .ctl_init_done_for_seq(ctl_o), .phs_shft_busy_for_seq(phs_o), .seq_running(run_o),
    .startup_state(st_o), .busy_timeout_err(err_o), .cal_pass_sticky(pass_o), .cal_count(cnt_o));

  seq_startup_ctrl #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .BUSY_TIMEOUT(TO),
                     .RECAL_HOLD(HOLD), .CNT_WIDTH(16), .BYPASS(1'b1)) dut_bp (
    .seq_clk(clk), .reset_seq_n(rst_n), .ctl_init_done(bp_init), .phs_shft_busy(bp_busy),
    .recal_req(bp_recal), .seq_cal_done(bp_cal), .seq_cal_success(bp_succ),
    .ctl_init_done_for_seq(bp_ctl), .phs_shft_busy_for_seq(bp_phs), .seq_running(bp_run),
    .startup_state(bp_st), .busy_timeout_err(bp_err), .cal_pass_sticky(bp_pass), .cal_count(bp_cnt));

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Advances until the state code is s; returns edges taken, or -1 if the budget expires.
  task automatic wait_state(input logic [2:0] s, input int limit, output int n);
    n = 0;
    while (st_o !== s && n < limit) begin step(); n++; end
    if (st_o !== s) n = -1;
  endtask

  task automatic do_reset(input logic init_v, input logic busy_v);
    rst_n = 1'b0; init = init_v; busy = busy_v; recal = 1'b0; cal_done = 1'b0; succ = 1'b0;
    bp_init = 1'b0; bp_busy = 1'b0; bp_recal = 1'b0; bp_cal = 1'b0; bp_succ = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    int n;
    do_reset(1'b1, 1'b0);
    wait_state(3'd3, 100, n);
    cal_done = 1'b1; succ = 1'b1;
    step();
    cal_done = 1'b0;
    n_total++;
    if (cnt_o !== 8'd1 || pass_o !== 1'b1) $display("FAIL pre_reset_cal: cnt=%0d pass=%0b expected 1/1", cnt_o, pass_o);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({ctl_o, phs_o, run_o, st_o, err_o, pass_o, cnt_o} !== 16'h0)
      $display("FAIL async_reset: outputs=%h expected 0000", {ctl_o, phs_o, run_o, st_o, err_o, pass_o, cnt_o});
    else n_pass++;
    step(2);
    n_total++;
    if ({ctl_o, phs_o, run_o, st_o, err_o, pass_o, cnt_o} !== 16'h0)
      $display("FAIL held_reset: outputs=%h expected 0000", {ctl_o, phs_o, run_o, st_o, err_o, pass_o, cnt_o});
    else n_pass++;
  endtask

  task automatic test_startup;
    int n, hold;
    logic [2:0] seen[$];
    logic [2:0] prev;
    do_reset(1'b1, 1'b0);
    prev = st_o; n = 0;
    while (st_o !== 3'd3 && n < 100) begin
      step(); n++;
      if (st_o !== prev) begin seen.push_back(st_o); prev = st_o; end
    end
    if (st_o !== 3'd3) n = -1;
    n_total++;
    if (n != GO_LAT) $display("FAIL startup_latency: got %0d edges expected %0d", n, GO_LAT);
    else n_pass++;
    n_total++;
    if (seen.size() != 3 || seen[0] !== 3'd1 || seen[1] !== 3'd2 || seen[2] !== 3'd3)
      $display("FAIL startup_sequence: %0d states seen, expected 1,2,3", seen.size());
    else n_pass++;
    n_total++;
    if (ctl_o !== 1'b1 || run_o !== 1'b1 || phs_o !== 1'b0)
      $display("FAIL startup_outputs: ctl=%0b run=%0b phs=%0b expected 1 1 0", ctl_o, run_o, phs_o);
    else n_pass++;
    busy = 1'b1; #1;
    n_total++;
    if (phs_o !== 1'b1) $display("FAIL busy_passthru_go: phs=%0b expected 1", phs_o);
    else n_pass++;
    busy = 1'b0; #1;
    repeat (3) begin
      do_reset(1'b1, 1'b1);
      hold = $urandom_range(5, 300);
      step(hold);
      n_total++;
      if (st_o !== 3'd1 || phs_o !== 1'b0 || ctl_o !== 1'b0)
        $display("FAIL wait_gated: st=%0d phs=%0b ctl=%0b expected 1 0 0", st_o, phs_o, ctl_o);
      else n_pass++;
      busy = 1'b0;
      wait_state(3'd3, 200, n);
      n_total++;
      if (n != GO_LAT) $display("FAIL busy_drop_latency: hold=%0d got %0d expected %0d", hold, n, GO_LAT);
      else n_pass++;
    end
  endtask

  task automatic test_glitch;
    int n, c, len;
    bit seen_wait, early;
    for (int it = 0; it < 4; it++) begin
      do_reset(1'b1, 1'b0);
      wait_state(3'd2, 50, n);
      c   = (it == 0) ? 10 : $urandom_range(0, 12);
      len = (it == 0) ? 3  : $urandom_range(1, 5);
      step(c);
      seen_wait = 1'b0; early = 1'b0;
      busy = 1'b1;
      for (int k = 0; k < len; k++) begin
        step();
        if (st_o === 3'd1) seen_wait = 1'b1;
        if (ctl_o !== 1'b0) early = 1'b1;
      end
      busy = 1'b0;
      n = 0;
      while (st_o !== 3'd3 && n < 100) begin
        step(); n++;
        if (st_o === 3'd1) seen_wait = 1'b1;
        if (st_o !== 3'd3 && ctl_o !== 1'b0) early = 1'b1;
      end
      if (st_o !== 3'd3) n = -1;
      n_total++;
      if (n != GO_LAT || !seen_wait || early)
        $display("FAIL settle_glitch: c=%0d len=%0d edges=%0d (exp %0d) wait_seen=%0b early_ctl=%0b",
                 c, len, n, GO_LAT, seen_wait, early);
      else n_pass++;
    end
  endtask

  task automatic test_timeout;
    int n;
    do_reset(1'b1, 1'b1);
    wait_state(3'd6, 1200, n);
    n_total++;
    if (n != 1 + TO || err_o !== 1'b1)
      $display("FAIL timeout: edges=%0d err=%0b expected %0d and 1", n, err_o, 1 + TO);
    else n_pass++;
    step($urandom_range(1, 20));
    n_total++;
    if (st_o !== 3'd6 || err_o !== 1'b1 || run_o !== 1'b0)
      $display("FAIL error_hold: st=%0d err=%0b run=%0b expected 6 1 0", st_o, err_o, run_o);
    else n_pass++;
    recal = 1'b1;
    step();
    recal = 1'b0;
    n_total++;
    if (st_o !== 3'd0 || err_o !== 1'b0)
      $display("FAIL error_recover: st=%0d err=%0b expected 0 0", st_o, err_o);
    else n_pass++;
    // busy falls so the synchronised level is first seen low on the timeout edge
    do_reset(1'b1, 1'b1);
    step(TO - 2);
    busy = 1'b0;
    wait_state(3'd6, 20, n);
    n_total++;
    if (n != SYNC + 1 || err_o !== 1'b1)
      $display("FAIL timeout_priority: edges=%0d err=%0b expected %0d and 1", n, err_o, SYNC + 1);
    else n_pass++;
  endtask

  task automatic test_recal;
    int n, hold;
    bit ran;
    do_reset(1'b1, 1'b0);
    wait_state(3'd3, 100, n);
    step($urandom_range(1, 10));
    cal_done = 1'b1; succ = 1'b1;
    step();
    cal_done = 1'b0;
    n_total++;
    if (st_o !== 3'd4 || cnt_o !== 8'd1 || pass_o !== 1'b1 || run_o !== 1'b1 || ctl_o !== 1'b1)
      $display("FAIL first_cal: st=%0d cnt=%0d pass=%0b run=%0b ctl=%0b expected 4 1 1 1 1",
               st_o, cnt_o, pass_o, run_o, ctl_o);
    else n_pass++;
    step();
    cal_done = 1'b1; succ = 1'b0;
    step();
    cal_done = 1'b0;
    n_total++;
    if (st_o !== 3'd4 || cnt_o !== 8'd1 || pass_o !== 1'b1)
      $display("FAIL second_cal_edge: st=%0d cnt=%0d pass=%0b expected 4 1 1", st_o, cnt_o, pass_o);
    else n_pass++;
    recal = 1'b1;
    step();
    recal = 1'b0;
    hold = 0; ran = 1'b0;
    while (st_o === 3'd5 && hold < 50) begin
      hold++;
      if (run_o !== 1'b0 || ctl_o !== 1'b0) ran = 1'b1;
      recal = (hold == 3);
      step();
    end
    recal = 1'b0;
    n_total++;
    if (hold != HOLD || st_o !== 3'd0 || ran)
      $display("FAIL recal_hold: recal cycles=%0d then st=%0d run_seen=%0b expected %0d then 0",
               hold, st_o, ran, HOLD);
    else n_pass++;
    wait_state(3'd3, 100, n);
    n_total++;
    if (n != 1 + SETTLE) $display("FAIL recal_restart: edges=%0d expected %0d", n, 1 + SETTLE);
    else n_pass++;
    cal_done = 1'b1; succ = 1'b0;
    step();
    cal_done = 1'b0;
    n_total++;
    if (st_o !== 3'd4 || cnt_o !== 8'd2 || pass_o !== 1'b0)
      $display("FAIL recal_second_cal: st=%0d cnt=%0d pass=%0b expected 4 2 0", st_o, cnt_o, pass_o);
    else n_pass++;
  endtask

  task automatic test_pending;
    int n;
    do_reset(1'b1, 1'b0);
    wait_state(3'd3, 100, n);
    recal = 1'b1;
    step();
    recal = 1'b0;
    step($urandom_range(1, 5));
    n_total++;
    if (st_o !== 3'd3) $display("FAIL go_recal_latched: st=%0d expected 3", st_o);
    else n_pass++;
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    n_total++;
    if (st_o !== 3'd4 || cnt_o !== 8'd1) $display("FAIL pending_caldone: st=%0d cnt=%0d expected 4 1", st_o, cnt_o);
    else n_pass++;
    step();
    n_total++;
    if (st_o !== 3'd5) $display("FAIL pending_recal: st=%0d expected 5", st_o);
    else n_pass++;
    wait_state(3'd3, 100, n);
    recal = 1'b1; cal_done = 1'b1;
    step();
    recal = 1'b0; cal_done = 1'b0;
    n_total++;
    if (st_o !== 3'd4 || cnt_o !== 8'd2) $display("FAIL simul_cal_recal: st=%0d cnt=%0d expected 4 2", st_o, cnt_o);
    else n_pass++;
    step();
    n_total++;
    if (st_o !== 3'd5) $display("FAIL simul_then_recal: st=%0d expected 5", st_o);
    else n_pass++;
  endtask

  task automatic test_priority;
    int n;
    do_reset(1'b1, 1'b0);
    wait_state(3'd3, 100, n);
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    init = 1'b0; recal = 1'b1;
    step();
    recal = 1'b0;
    n_total++;
    if (st_o !== 3'd0 || run_o !== 1'b0 || ctl_o !== 1'b0)
      $display("FAIL init_drop_caldone: st=%0d run=%0b ctl=%0b expected 0 0 0", st_o, run_o, ctl_o);
    else n_pass++;
    init = 1'b1;
    wait_state(3'd3, 100, n);
    recal = 1'b1;
    step();
    recal = 1'b0;
    init = 1'b0;
    step();
    init = 1'b1;
    wait_state(3'd3, 100, n);
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    step(3);
    n_total++;
    if (st_o !== 3'd4) $display("FAIL pending_cleared: st=%0d expected 4", st_o);
    else n_pass++;
    init = 1'b0;
    step();
    init = 1'b1;
    step(1 + $urandom_range(1, 10));
    init = 1'b0;
    step();
    n_total++;
    if (st_o !== 3'd0 || run_o !== 1'b0) $display("FAIL init_drop_settle: st=%0d run=%0b expected 0 0", st_o, run_o);
    else n_pass++;
    init = 1'b1;
  endtask

  task automatic test_saturation;
    int n, w;
    int exp_cnt;
    logic s;
    do_reset(1'b1, 1'b0);
    wait_state(3'd3, 100, w);
    n = 0;
    for (int it = 0; it < 258; it++) begin
      s = 1'($urandom);
      succ = s; cal_done = 1'b1;
      step();
      cal_done = 1'b0;
      n++;
      exp_cnt = (n > 255) ? 255 : n;
      n_total++;
      if (st_o !== 3'd4 || cnt_o !== 8'(exp_cnt) || pass_o !== s)
        $display("FAIL cal_count_model: cal %0d st=%0d cnt=%0d pass=%0b expected 4 %0d %0b",
                 n, st_o, cnt_o, pass_o, exp_cnt, s);
      else n_pass++;
      init = 1'b0;
      step();
      init = 1'b1;
      wait_state(3'd3, 60, w);
    end
  endtask

  task automatic test_bypass;
    int n;
    logic s;
    do_reset(1'b0, 1'b0);
    n = 0;
    for (int it = 0; it < 24; it++) begin
      bp_init = 1'($urandom); bp_busy = 1'($urandom);
      #1;
      n_total++;
      if ({bp_ctl, bp_phs, bp_run, bp_st, bp_err} !== {bp_init, bp_busy, 1'b1, 3'd3, 1'b0})
        $display("FAIL bypass_passthru: ctl=%0b phs=%0b run=%0b st=%0d err=%0b expected %0b %0b 1 3 0",
                 bp_ctl, bp_phs, bp_run, bp_st, bp_err, bp_init, bp_busy);
      else n_pass++;
      if (it % 4 == 0) begin
        s = 1'($urandom);
        bp_succ = s; bp_cal = 1'b1;
        step();
        bp_cal = 1'b0;
        step();
        n++;
        n_total++;
        if (bp_cnt !== 8'(n) || bp_pass !== s)
          $display("FAIL bypass_cal: cnt=%0d pass=%0b expected %0d %0b", bp_cnt, bp_pass, n, s);
        else n_pass++;
      end else begin
        step($urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; init = 1'b0; busy = 1'b0; recal = 1'b0; cal_done = 1'b0; succ = 1'b0;
    bp_init = 1'b0; bp_busy = 1'b0; bp_recal = 1'b0; bp_cal = 1'b0; bp_succ = 1'b0;
    test_reset();
    test_startup();
    test_glitch();
    test_timeout();
    test_recal();
    test_pending();
    test_priority();
    test_saturation();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
